// File: rtl/text_console_writer_pkg.sv
// Shared constants, control codes and FSM state type for the text console writer.
package text_console_writer_pkg;

   localparam int         DEF_COLS   = 80;
   localparam int         DEF_ROWS   = 30;
   localparam int         DEF_ADDR_W = 12;
   localparam logic [7:0] DEF_BLANK  = 8'h20;

   localparam int COL_W = 7;
   localparam int ROW_W = 5;

   localparam logic [7:0] CHR_BS = 8'h08;
   localparam logic [7:0] CHR_LF = 8'h0A;
   localparam logic [7:0] CHR_FF = 8'h0C;
   localparam logic [7:0] CHR_CR = 8'h0D;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCROLL,
      ST_SCROLL_FILL,
      ST_CLEAR
   } state_t;

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= 8'h20) && (b <= 8'h7E);
   endfunction

endpackage

// File: rtl/text_console_writer_cursor.sv
// Cursor column/row plus the matching linear text RAM address, kept without a multiplier.
module console_cursor
   import text_console_writer_pkg::*;
#(
   parameter int COLS   = DEF_COLS,
   parameter int ROWS   = DEF_ROWS,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_inc,
   input  logic              i_newline,
   input  logic              i_cr,
   input  logic              i_back,
   input  logic              i_home,
   output logic [COL_W-1:0]  o_col,
   output logic [ROW_W-1:0]  o_row,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_at_last_col,
   output logic              o_at_last_row
);

   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
   localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((ROWS - 1) * COLS);
   localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);

   logic [COL_W-1:0]  r_col;
   logic [ROW_W-1:0]  r_row;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_row_base;

   assign w_row_base    = r_addr - ADDR_W'(r_col);
   assign o_at_last_col = (r_col == LAST_COL);
   assign o_at_last_row = (r_row == LAST_ROW);
   assign o_col         = r_col;
   assign o_row         = r_row;
   assign o_addr        = r_addr;

   // On the bottom row, wrap and newline park the cursor at the row start; the scroll moves the text.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col  <= '0;
         r_row  <= '0;
         r_addr <= '0;
      end else if (i_home) begin
         r_col  <= '0;
         r_row  <= '0;
         r_addr <= '0;
      end else if (i_inc) begin
         if (o_at_last_col) begin
            r_col <= '0;
            if (o_at_last_row) begin
               r_addr <= LAST_BASE;
            end else begin
               r_row  <= r_row + 1'b1;
               r_addr <= r_addr + 1'b1;
            end
         end else begin
            r_col  <= r_col + 1'b1;
            r_addr <= r_addr + 1'b1;
         end
      end else if (i_newline) begin
         r_col <= '0;
         if (o_at_last_row) begin
            r_addr <= LAST_BASE;
         end else begin
            r_row  <= r_row + 1'b1;
            r_addr <= w_row_base + ROW_STEP;
         end
      end else if (i_cr) begin
         r_col  <= '0;
         r_addr <= w_row_base;
      end else if (i_back && (r_col != '0)) begin
         r_col  <= r_col - 1'b1;
         r_addr <= r_addr - 1'b1;
      end
   end

endmodule

// File: rtl/text_console_writer.sv
// Writer side of the character text buffer: byte stream in, text RAM writes out,
// with cursor control codes, line wrap, scroll-up and clear-screen.
module text_console_writer
   import text_console_writer_pkg::*;
#(
   parameter int         COLS   = DEF_COLS,
   parameter int         ROWS   = DEF_ROWS,
   parameter int         ADDR_W = DEF_ADDR_W,
   parameter logic [7:0] BLANK  = DEF_BLANK
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] ram_raddr,
   input  logic [7:0]        ram_rdata,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [7:0]        ram_wdata,
   output logic              ram_we,
   output logic [6:0]        cur_col,
   output logic [4:0]        cur_row,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((ROWS - 1) * COLS);

   state_t            r_state;
   logic [ADDR_W-1:0] r_raddr;
   logic [ADDR_W-1:0] r_waddr;
   logic [7:0]        r_wdata;
   logic              r_we;
   logic              r_copy;

   logic              w_accept;
   logic              w_print;
   logic              w_inc;
   logic              w_nl;
   logic              w_cr;
   logic              w_bs;
   logic              w_home;
   logic [COL_W-1:0]  w_col;
   logic [ROW_W-1:0]  w_row;
   logic [ADDR_W-1:0] w_addr;
   logic              w_last_col;
   logic              w_last_row;

   always_comb begin
      w_accept = in_valid && (r_state == ST_IDLE);
      w_print  = is_printable(in_data);
      w_inc    = w_accept && w_print;
      w_nl     = w_accept && (in_data == CHR_LF);
      w_cr     = w_accept && (in_data == CHR_CR);
      w_bs     = w_accept && (in_data == CHR_BS) && (w_col != '0);
      w_home   = w_accept && (in_data == CHR_FF);
   end

   console_cursor #(
      .COLS   (COLS),
      .ROWS   (ROWS),
      .ADDR_W (ADDR_W)
   ) u_cursor (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_inc         (w_inc),
      .i_newline     (w_nl),
      .i_cr          (w_cr),
      .i_back        (w_bs),
      .i_home        (w_home),
      .o_col         (w_col),
      .o_row         (w_row),
      .o_addr        (w_addr),
      .o_at_last_col (w_last_col),
      .o_at_last_row (w_last_row)
   );

   // Copy writes forward the RAM read data directly so each copy costs one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_raddr <= '0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
         r_copy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_we   <= 1'b0;
               r_copy <= 1'b0;
               if (w_accept) begin
                  if (w_print) begin
                     r_we    <= 1'b1;
                     r_waddr <= w_addr;
                     r_wdata <= in_data;
                     if (w_last_col && w_last_row) begin
                        r_state <= ST_SCROLL;
                        r_raddr <= ROW_STEP;
                     end
                  end else if (in_data == CHR_LF) begin
                     if (w_last_row) begin
                        r_state <= ST_SCROLL;
                        r_raddr <= ROW_STEP;
                     end
                  end else if (w_bs) begin
                     r_we    <= 1'b1;
                     r_waddr <= w_addr - 1'b1;
                     r_wdata <= BLANK;
                  end else if (in_data == CHR_FF) begin
                     r_state <= ST_CLEAR;
                     r_we    <= 1'b1;
                     r_waddr <= '0;
                     r_wdata <= BLANK;
                  end
               end
            end
            ST_SCROLL: begin
               r_we    <= 1'b1;
               r_copy  <= 1'b1;
               r_waddr <= r_raddr - ROW_STEP;
               if (r_raddr == LAST_ADDR) begin
                  r_state <= ST_SCROLL_FILL;
                  r_raddr <= '0;
               end else begin
                  r_raddr <= r_raddr + 1'b1;
               end
            end
            ST_SCROLL_FILL: begin
               if (r_copy) begin
                  r_copy  <= 1'b0;
                  r_we    <= 1'b1;
                  r_waddr <= LAST_BASE;
                  r_wdata <= BLANK;
               end else if (r_waddr == LAST_ADDR) begin
                  r_we    <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_waddr <= r_waddr + 1'b1;
               end
            end
            ST_CLEAR: begin
               if (r_waddr == LAST_ADDR) begin
                  r_we    <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_waddr <= r_waddr + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_we    <= 1'b0;
               r_copy  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign busy      = ~in_ready;
   assign ram_raddr = r_raddr;
   assign ram_waddr = r_waddr;
   assign ram_wdata = r_copy ? ram_rdata : r_wdata;
   assign ram_we    = r_we;
   assign cur_col   = w_col;
   assign cur_row   = w_row;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a behavioural 1-cycle-read text RAM.
module tb_text_console_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic [11:0] ram_raddr;
   logic [7:0]  ram_rdata;
   logic [11:0] ram_waddr;
   logic [7:0]  ram_wdata;
   logic        ram_we;
   logic [6:0]  cur_col;
   logic [4:0]  cur_row;
   logic        busy;

   logic [7:0]  mem [0:4095];
   int unsigned wr_total = 0;
   int unsigned bad_wr = 0;
   int unsigned conflict = 0;
   logic        mon_scroll = 1'b0;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   text_console_writer #(
      .COLS   (80),
      .ROWS   (30),
      .ADDR_W (12),
      .BLANK  (8'h20)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .ram_raddr (ram_raddr),
      .ram_rdata (ram_rdata),
      .ram_waddr (ram_waddr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .cur_col   (cur_col),
      .cur_row   (cur_row),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ram_rdata <= mem[ram_raddr];
      if (ram_we) begin
         mem[ram_waddr] <= ram_wdata;
         wr_total = wr_total + 1;
         if (ram_waddr >= 12'd2400) bad_wr = bad_wr + 1;
         if (mon_scroll && busy && (ram_waddr == ram_raddr)) conflict = conflict + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Returns at the negedge of the cycle right after the accepting edge.
   task automatic send(input logic [7:0] b);
      int unsigned guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      check("send_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic count_busy(output int unsigned n);
      n = 0;
      while (busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int unsigned n;
      int unsigned w0;
      int unsigned errs;
      int unsigned guard;

      for (int i = 0; i < 4096; i++) mem[i] = 8'hEE;

      // Reset state
      #12;
      check("rst_we",    {31'd0, ram_we},    32'd0);
      check("rst_waddr", {20'd0, ram_waddr}, 32'd0);
      check("rst_wdata", {24'd0, ram_wdata}, 32'd0);
      check("rst_raddr", {20'd0, ram_raddr}, 32'd0);
      check("rst_col",   {25'd0, cur_col},   32'd0);
      check("rst_row",   {27'd0, cur_row},   32'd0);
      check("rst_ready", {31'd0, in_ready},  32'd1);
      check("rst_busy",  {31'd0, busy},      32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: "AB" back to back
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h41;
      @(negedge clk);
      check("ab_we_a",    {31'd0, ram_we},    32'd1);
      check("ab_addr_a",  {20'd0, ram_waddr}, 32'd0);
      check("ab_data_a",  {24'd0, ram_wdata}, 32'h41);
      check("ab_ready_a", {31'd0, in_ready},  32'd1);
      in_data = 8'h42;
      @(negedge clk);
      in_valid = 1'b0;
      check("ab_we_b",   {31'd0, ram_we},    32'd1);
      check("ab_addr_b", {20'd0, ram_waddr}, 32'd1);
      check("ab_data_b", {24'd0, ram_wdata}, 32'h42);
      check("ab_col",    {25'd0, cur_col},   32'd2);
      check("ab_row",    {27'd0, cur_row},   32'd0);

      // 2: line wrap
      send(8'h0D);
      check("cr_col", {25'd0, cur_col}, 32'd0);
      for (int i = 0; i < 80; i++) send(8'h78);
      check("wrap_col", {25'd0, cur_col}, 32'd0);
      check("wrap_row", {27'd0, cur_row}, 32'd1);
      send(8'h79);
      check("y_we",   {31'd0, ram_we},    32'd1);
      check("y_addr", {20'd0, ram_waddr}, 32'd80);
      check("y_data", {24'd0, ram_wdata}, 32'h79);
      check("y_col",  {25'd0, cur_col},   32'd1);
      check("y_row",  {27'd0, cur_row},   32'd1);

      // 3: scroll from the bottom row
      send(8'h0D);
      for (int i = 0; i < 28; i++) send(8'h0A);
      check("lf_col", {25'd0, cur_col}, 32'd0);
      check("lf_row", {27'd0, cur_row}, 32'd29);
      for (int r = 0; r < 30; r++)
         for (int c = 0; c < 80; c++) mem[r*80 + c] = 8'(8'h30 + r);
      w0 = wr_total;
      mon_scroll = 1'b1;
      send(8'h0A);
      count_busy(n);
      mon_scroll = 1'b0;
      check("scroll_busy_cycles", n, 32'd2401);
      check("scroll_writes", wr_total - w0, 32'd2400);
      for (int r = 0; r < 30; r++) begin
         errs = 0;
         for (int c = 0; c < 80; c++)
            if (mem[r*80 + c] !== ((r == 29) ? 8'h20 : 8'(8'h31 + r))) errs++;
         check($sformatf("scroll_row%0d_bad_words", r), errs, 32'd0);
      end
      check("scroll_col", {25'd0, cur_col}, 32'd0);
      check("scroll_row", {27'd0, cur_row}, 32'd29);
      check("scroll_rw_conflicts", conflict, 32'd0);

      // 4: clear screen
      w0 = wr_total;
      send(8'h0C);
      count_busy(n);
      check("clear_busy_cycles", n, 32'd2400);
      check("clear_writes", wr_total - w0, 32'd2400);
      errs = 0;
      for (int i = 0; i < 2400; i++) if (mem[i] !== 8'h20) errs++;
      check("clear_nonblank_words", errs, 32'd0);
      check("clear_col", {25'd0, cur_col}, 32'd0);
      check("clear_row", {27'd0, cur_row}, 32'd0);

      // 5: backspace
      for (int i = 0; i < 3; i++) send(8'h0A);
      for (int i = 0; i < 5; i++) send(8'h61);
      check("pre_bs_col", {25'd0, cur_col}, 32'd5);
      check("pre_bs_row", {27'd0, cur_row}, 32'd3);
      send(8'h08);
      check("bs_we",   {31'd0, ram_we},    32'd1);
      check("bs_addr", {20'd0, ram_waddr}, 32'd244);
      check("bs_data", {24'd0, ram_wdata}, 32'h20);
      check("bs_col",  {25'd0, cur_col},   32'd4);
      check("bs_row",  {27'd0, cur_row},   32'd3);
      send(8'h0D);
      w0 = wr_total;
      send(8'h08);
      check("bs0_we", {31'd0, ram_we}, 32'd0);
      @(negedge clk);
      check("bs0_writes", wr_total - w0, 32'd0);
      check("bs0_col", {25'd0, cur_col}, 32'd0);
      check("bs0_row", {27'd0, cur_row}, 32'd3);

      // 6: reset in the middle of a scroll
      for (int i = 0; i < 26; i++) send(8'h0A);
      check("pre_abort_row", {27'd0, cur_row}, 32'd29);
      send(8'h0A);
      guard = 0;
      while (ram_raddr != 12'd1000 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      check("abort_reach_idx", {20'd0, ram_raddr}, 32'd1000);
      rst_n = 1'b0;
      #1;
      check("abort_we",    {31'd0, ram_we},   32'd0);
      check("abort_col",   {25'd0, cur_col},  32'd0);
      check("abort_row",   {27'd0, cur_row},  32'd0);
      check("abort_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      send(8'h5A);
      check("z_we",   {31'd0, ram_we},    32'd1);
      check("z_addr", {20'd0, ram_waddr}, 32'd0);
      check("z_data", {24'd0, ram_wdata}, 32'h5A);
      check("z_col",  {25'd0, cur_col},   32'd1);

      @(negedge clk);
      check("out_of_range_writes", bad_wr, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
